// File: rtl/spi_top.sv
// -----------------------------------------------------------------------------
// spi_top
//   Single-clock SPI subsystem: one SPI master and one SPI slave (slave 1)
//   joined by an internal serial bus (sclk enable, mosi, miso, ss_n[3:0]).
//   The host loads a word into the master (up_data/data/top_ss) and a word
//   into the slave (up_data1/data1). A full-duplex, MSB-first exchange of
//   `width` bits follows. Afterwards m_data holds the word the master
//   received and s_data1 holds the word slave 1 received.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-low reset
//   up_data   in   master start strobe (sampled only while idle)
//   data      in   word for the master to transmit
//   top_ss    in   slave select index; only index 0 reaches slave 1
//   m_data    out  last word received by the master
//   up_data1  in   slave-1 load strobe (ignored while slave 1 is selected)
//   data1     in   word for slave 1 to transmit
//   s_data1   out  last word received by slave 1
// -----------------------------------------------------------------------------
module spi_top #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_data,
    input  logic [width-1:0] data,
    input  logic [1:0]       top_ss,
    output logic [width-1:0] m_data,
    input  logic             up_data1,
    input  logic [width-1:0] data1,
    output logic [width-1:0] s_data1
);

    localparam int CNT_W = $clog2(width);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [width-1:0]   master_sh;
    logic [width-1:0]   slave_sh;
    logic [3:0]         ss_n;

    // Internal serial bus
    logic sclk_en;
    logic mosi;
    logic miso;
    logic last_bit;

    assign sclk_en  = (state == XFER);
    assign last_bit = sclk_en && (cnt == LAST_BIT);
    assign mosi     = master_sh[width-1];
    // Selects 1..3 have no device behind them, so the bus reads 0.
    assign miso     = ss_n[0] ? 1'b0 : slave_sh[width-1];

    // -------------------------------------------------------------------------
    // Master: control FSM, shift register, chip selects and received word
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            master_sh <= '0;
            ss_n      <= 4'hF;
            m_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_data) begin
                        master_sh <= data;
                        cnt       <= '0;
                        ss_n      <= ~(4'b0001 << top_ss);
                        state     <= XFER;
                    end
                end
                XFER: begin
                    master_sh <= {master_sh[width-2:0], miso};
                    cnt       <= cnt + 1'b1;
                    if (last_bit) begin
                        m_data <= {master_sh[width-2:0], miso};
                        ss_n   <= 4'hF;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // One dead cycle with all selects released before the
                    // next start can be accepted.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Slave 1: shifts only while selected; host reload only while deselected,
    // which includes the start edge itself, so a same-edge load is transmitted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            slave_sh <= '0;
            s_data1  <= '0;
        end else if (sclk_en && !ss_n[0]) begin
            slave_sh <= {slave_sh[width-2:0], mosi};
            if (last_bit) begin
                s_data1 <= {slave_sh[width-2:0], mosi};
            end
        end else if (up_data1 && ss_n[0]) begin
            slave_sh <= data1;
        end
    end

endmodule

// File: tb/tb_spi_top.sv
module tb_spi_top;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_data;
    logic [W-1:0] data;
    logic [1:0]   top_ss;
    logic [W-1:0] m_data;
    logic         up_data1;
    logic [W-1:0] data1;
    logic [W-1:0] s_data1;

    spi_top #(.width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .up_data  (up_data),
        .data     (data),
        .top_ss   (top_ss),
        .m_data   (m_data),
        .up_data1 (up_data1),
        .data1    (data1),
        .s_data1  (s_data1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry: what the outputs and selects must look like at a cycle
    typedef struct {
        int           due;
        logic [W-1:0] m;
        logic [W-1:0] s;
        logic [3:0]   ss;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model state: plain words, no notion of bits or states
    logic [W-1:0] ref_slave;   // word slave 1 will transmit next
    logic [W-1:0] ref_m;       // visible m_data
    logic [W-1:0] ref_s;       // visible s_data1

    task automatic push(input int due, input logic [W-1:0] m, input logic [W-1:0] s,
                        input logic [3:0] ss, input string name);
        exp_t e;
        e.due = due; e.m = m; e.s = s; e.ss = ss; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare whenever an expectation falls due
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.due < cyc) begin
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.due, cyc);
            end else if (m_data !== e.m || s_data1 !== e.s || dut.ss_n !== e.ss) begin
                $display("FAIL %s @%0d: got m_data=%h s_data1=%h ss_n=%b, want m_data=%h s_data1=%h ss_n=%b",
                         e.name, cyc, m_data, s_data1, dut.ss_n, e.m, e.s, e.ss);
            end else begin
                passed++;
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Immediate check of the model's current view, due at the latest edge
    task automatic check_now(input string name);
        @(posedge clk); #1;
        push(cyc, ref_m, ref_s, 4'hF, name);
    endtask

    // Issue a start (optionally with a same-edge slave load). When track is
    // set the model is advanced and the exchange's expectations are queued.
    task automatic start_xfer(input logic [W-1:0] d, input logic [1:0] ts,
                              input bit ld1, input logic [W-1:0] d1,
                              input bit track, input string name, output int c0);
        logic [3:0] ss_act;
        @(negedge clk);
        up_data = 1'b1; data = d; top_ss = ts;
        up_data1 = ld1; data1 = d1;
        @(posedge clk); #1;
        c0 = cyc;
        if (track) begin
            ss_act = ~(4'b0001 << ts);
            // Outputs hold old values while the exchange is in flight
            push(c0,         ref_m, ref_s, ss_act, {name, "_start"});
            push(c0 + W - 1, ref_m, ref_s, ss_act, {name, "_mid"});
            if (ld1) ref_slave = d1;
            if (ts == 2'b00) begin
                ref_m     = ref_slave;
                ref_s     = d;
                ref_slave = d;
            end else begin
                ref_m = '0;
            end
            push(c0 + W,     ref_m, ref_s, 4'hF, {name, "_done"});
            push(c0 + W + 1, ref_m, ref_s, 4'hF, {name, "_hold"});
        end
        @(negedge clk);
        up_data = 1'b0; up_data1 = 1'b0;
    endtask

    task automatic xfer(input logic [W-1:0] d, input logic [1:0] ts,
                        input bit ld1, input logic [W-1:0] d1, input string name);
        int c0;
        start_xfer(d, ts, ld1, d1, 1'b1, name, c0);
        wait_cyc(c0 + W + 1);
    endtask

    initial begin
        int c0;
        rst = 1'b0; up_data = 1'b0; up_data1 = 1'b0;
        data = '0; data1 = '0; top_ss = 2'b00;
        ref_slave = '0; ref_m = '0; ref_s = '0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1 push(cyc, '0, '0, 4'hF, "reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic exchange and a 12-cycle stability check
        xfer(8'hA5, 2'b00, 1'b1, 8'hCD, "basic");
        repeat (11) @(posedge clk);
        check_now("basic_stable");

        // Unselected slave
        xfer(8'h3C, 2'b01, 1'b0, 8'h00, "unsel");

        // Back-to-back without slave reload: slave echoes its last received word
        xfer(8'h0F, 2'b00, 1'b0, 8'h00, "echo");

        // Strobes during an active transfer are ignored
        start_xfer(8'hA5, 2'b00, 1'b1, 8'hCD, 1'b1, "ignore", c0);
        wait_cyc(c0 + 3);
        up_data = 1'b1; data = 8'hFF; up_data1 = 1'b1; data1 = 8'h11;
        @(negedge clk);
        up_data = 1'b0; up_data1 = 1'b0;
        wait_cyc(c0 + W + 1);

        // Reset in the middle of a transfer
        start_xfer(8'h77, 2'b00, 1'b1, 8'h99, 1'b0, "abort", c0);
        wait_cyc(c0 + 3);
        rst = 1'b0;
        @(posedge clk); #1;
        ref_slave = '0; ref_m = '0; ref_s = '0;
        push(cyc, '0, '0, 4'hF, "mid_reset");
        @(negedge clk);
        rst = 1'b1;
        xfer(8'h5A, 2'b00, 1'b1, 8'h81, "after_reset");

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] d, d1;
            logic [1:0]   ts;
            bit           ld1;
            d   = W'($urandom);
            d1  = W'($urandom);
            ts  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ld1 = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) begin
                // Standalone slave load while idle
                @(negedge clk);
                up_data1 = 1'b1; data1 = W'($urandom);
                @(posedge clk); #1;
                ref_slave = data1;
                @(negedge clk);
                up_data1 = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(d, ts, ld1, d1, $sformatf("rand%0d", i));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            $display("FAIL %s: never checked, want m_data=%h s_data1=%h", e.name, e.m, e.s);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_top.md
Name: spi_top

Overview:
- Single-clock SPI subsystem: one SPI master plus one SPI slave (slave 1), connected by an internal serial bus (sclk enable, mosi, miso, active-low selects).
- Host loads a word into the master and a word into the slave; a full-duplex exchange of `width` bits follows, MSB first.
- After the exchange the master exposes the slave's word on m_data, and the slave exposes the master's word on s_data1.
- Used as the integration/verification top for the SPI master and slave blocks.

Parameters:
- width, 8, word length in bits (>=2); sets every data port width and the bit counter size ($clog2(width)).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk).
- up_data  in  1  master start strobe; samples data and top_ss.
- data  in  width  word for the master to transmit.
- top_ss  in  2  slave select index for the transaction.
- m_data  out  width  last word received by the master.
- up_data1  in  1  slave-1 load strobe; samples data1.
- data1  in  width  word for slave 1 to transmit.
- s_data1  out  width  last word received by slave 1.

Behaviour:
- Reset (rst==0 at posedge):
  - Master FSM goes to IDLE.
  - All shift registers, bit counter, m_data and s_data1 clear to 0.
  - All four internal ss_n lines go high.
  - Reset overrides everything, including mid-transfer; the aborted transfer updates no output.
- top_ss decode to ss_n[3:0] (active-low): only ss_n[0] (top_ss==2'b00) is wired to slave 1. Indices 1–3 select no device; miso then reads 0.
- Master FSM states: IDLE, XFER, DONE.
  - IDLE: at edge E0 with up_data==1: load master shift reg with data, latch top_ss, counter=0, go to XFER. Drive ss_n[top_ss] low from after E0.
  - XFER: at edges E1..E(width), shift both registers one bit per clk (sclk enable = 1). mosi = master_sh[MSB] and miso = selected slave_sh[MSB], both combinational. Update: master_sh <= {master_sh[width-2:0], miso}; slave_sh <= {slave_sh[width-2:0], mosi}.
  - At E(width), the last shift: m_data <= final master word; s_data1 <= final slave word (slave only if it was selected); ss_n all high; go to DONE.
  - DONE: one cycle, then IDLE.
  - up_data is ignored outside IDLE. Next start is sampled no earlier than E(width+2).
- Latency: outputs are valid after the edge `width` cycles after the start edge (8 for the default).
- Slave 1:
  - up_data1==1 while ss_n[0] is high: load slave_sh <= data1.
  - up_data1 while ss_n[0] is low: ignored.
  - up_data1 and up_data on the same edge: the slave load takes effect at that edge, so the slave transmits data1 in that transfer.
  - After a transfer, slave_sh holds the received word. A following transfer without a reload returns that word.
- Unselected slave: shift register and s_data1 hold their values.
- Outputs hold their values between transfers.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> m_data=0x00, s_data1=0x00, all ss_n high, FSM in IDLE.
- Basic exchange: one-cycle pulse on up_data and up_data1 at the same edge, data=0xA5, data1=0xCD, top_ss=00 -> after 8 cycles m_data=0xCD and s_data1=0xA5. ss_n[0] low for exactly 8 cycles; outputs stable through a 12-cycle wait.
- Unselected slave: top_ss=01, data=0x3C, after the basic test -> m_data=0x00, s_data1 stays 0xA5, ss_n[0] stays high.
- Back-to-back, no slave reload: after the basic test, start with data=0x0F only -> m_data=0xA5 (echo of the previous received word), s_data1=0x0F.
- Ignored strobes: pulse up_data with data=0xFF and up_data1 with data1=0x11 at bit 3 of an active 0xA5/0xCD transfer -> result unchanged (m_data=0xCD, s_data1=0xA5).
- Reset mid-transfer: rst=0 at bit 4 -> outputs 0x00, ss_n high. A fresh transfer with 0x5A/0x81 then yields m_data=0x81, s_data1=0x5A.
